instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 159 +++++++++++++++
 tb/tb_instr_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction field bundles into 32-bit words with IMEM addresses.
// Latency: encoded word registered 1 cycle after acceptance; sustains 1 instr/cycle with out_ready high.
// Backpressure: one-entry output register, in_ready = !out_valid || out_ready; word held while stalled.
module instr_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   input  logic [13:0] start_addr,
   input  logic        load_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [13:0] out_addr,
   output logic        err,
   output logic [1:0]  err_code,
   input  logic        err_clr,
   output logic [15:0] count
);

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_OPCODE = 2'b01,
      ERR_RANGE  = 2'b10,
      ERR_ALIGN  = 2'b11
   } err_code_t;

   // Output word and its IMEM address travel together through the output register.
   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] instr;
   } out_word_t;

   out_word_t   out_q;
   logic [13:0] addr_cnt;
   err_code_t   err_code_q;

   logic [31:0] enc_word;
   err_code_t   enc_err;
   logic        accept;
   logic        emit;
   logic        is_shift;
   logic        i_fits;
   logic        b_fits;
   logic        j_fits;
   logic [13:0] base_addr;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign emit      = accept && (enc_err == ERR_NONE);
   // A same-cycle address load applies to the instruction being accepted.
   assign base_addr = load_addr ? start_addr : addr_cnt;

   assign out_instr = out_q.instr;
   assign out_addr  = out_q.addr;
   assign err_code  = err_code_q;

   // Immediate fits its field when all bits above the field's sign bit match it.
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign i_fits   = (&imm[31:11]) || !(|imm[31:11]);
   assign b_fits   = (&imm[31:12]) || !(|imm[31:12]);
   assign j_fits   = (&imm[31:20]) || !(|imm[31:20]);

   // Field packing per instruction format plus error classification of the bundle.
   always_comb begin
      enc_word = '0;
      enc_err  = ERR_NONE;
      case (opcode)
         OPC_R: begin
            enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         OPC_IMM: begin
            if (is_shift) begin
               enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            end else begin
               enc_word = {imm[11:0], rs1, funct3, rd, opcode};
               if (!i_fits) enc_err = ERR_RANGE;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            if (!i_fits) enc_err = ERR_RANGE;
         end
         OPC_STORE: begin
            enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            if (!i_fits) enc_err = ERR_RANGE;
         end
         OPC_BRANCH: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            if (!b_fits)     enc_err = ERR_RANGE;
            else if (imm[0]) enc_err = ERR_ALIGN;
         end
         OPC_LUI, OPC_AUIPC: begin
            enc_word = {imm[31:12], rd, opcode};
         end
         OPC_JAL: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            if (!j_fits)     enc_err = ERR_RANGE;
            else if (imm[0]) enc_err = ERR_ALIGN;
         end
         default: begin
            enc_err = ERR_OPCODE;
         end
      endcase
   end

   // Output register, address counter and emitted-instruction count.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_q     <= '0;
         addr_cnt  <= '0;
         count     <= '0;
      end else begin
         if (emit) begin
            out_valid    <= 1'b1;
            out_q.instr  <= enc_word;
            out_q.addr   <= base_addr;
            addr_cnt     <= base_addr + 14'd1;
            if (count != 16'hFFFF) count <= count + 16'd1;
         end else begin
            if (out_ready) out_valid <= 1'b0;
            if (load_addr) addr_cnt  <= start_addr;
         end
      end
   end

   // Sticky error flag keeping the first error code; a new error beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err        <= 1'b0;
         err_code_q <= ERR_NONE;
      end else if (accept && (enc_err != ERR_NONE)) begin
         err <= 1'b1;
         if (!err || err_clr) err_code_q <= enc_err;
      end else if (err_clr) begin
         err        <= 1'b0;
         err_code_q <= ERR_NONE;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a reference model.
// Latency: model predicts every output each cycle, sampled on the falling clock edge.
// Backpressure: out_ready is driven directly, including long stalls and random toggling.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic [13:0] start_addr;
   logic        load_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [13:0] out_addr;
   logic        err;
   logic [1:0]  err_code;
   logic        err_clr;
   logic [15:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (reset values)
   bit        m_vld   = 0;
   bit [31:0] m_instr = 0;
   int        m_oaddr = 0;
   int        m_acnt  = 0;
   int        m_count = 0;
   bit        m_err   = 0;
   int        m_code  = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .funct3     (funct3),
      .funct7     (funct7),
      .imm        (imm),
      .start_addr (start_addr),
      .load_addr  (load_addr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .err        (err),
      .err_code   (err_code),
      .err_clr    (err_clr),
      .count      (count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Encoding from the ISA format rules using integer arithmetic; code 0 means legal.
   function automatic void ref_encode(output bit [31:0] w, output int code);
      int        sv;
      bit [31:0] u, o, d, s1, s2, f3, f7;
      sv = $signed(imm);
      u  = imm;
      o  = 32'(opcode);
      d  = 32'(rd) << 7;
      s1 = 32'(rs1) << 15;
      s2 = 32'(rs2) << 20;
      f3 = 32'(funct3) << 12;
      f7 = 32'(funct7) << 25;
      w    = 0;
      code = 0;
      case (opcode)
         7'h33: w = f7 | s2 | s1 | f3 | d | o;
         7'h13, 7'h03, 7'h67: begin
            if (opcode == 7'h13 && (funct3 == 1 || funct3 == 5))
               w = f7 | ((u % 32) << 20) | s1 | f3 | d | o;
            else begin
               w = ((u % 4096) << 20) | s1 | f3 | d | o;
               if (sv < -2048 || sv > 2047) code = 2;
            end
         end
         7'h23: begin
            w = (((u / 32) % 128) << 25) | s2 | s1 | f3 | ((u % 32) << 7) | o;
            if (sv < -2048 || sv > 2047) code = 2;
         end
         7'h63: begin
            w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | s2 | s1 | f3 |
                (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | o;
            if (sv < -4096 || sv > 4095) code = 2;
            else if (u % 2 == 1) code = 3;
         end
         7'h37, 7'h17: w = (u - (u % 4096)) | d | o;
         7'h6F: begin
            w = (((u / (1 << 20)) % 2) << 31) | (((u / 2) % 1024) << 21) |
                (((u / 2048) % 2) << 20) | (((u / 4096) % 256) << 12) | d | o;
            if (sv < -(1 << 20) || sv > (1 << 20) - 1) code = 2;
            else if (u % 2 == 1) code = 3;
         end
         default: code = 1;
      endcase
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit        acc;
      int        base, code;
      bit [31:0] w;
      if (rst) begin
         m_vld = 0; m_instr = 0; m_oaddr = 0; m_acnt = 0; m_count = 0; m_err = 0; m_code = 0;
         return;
      end
      acc  = in_valid && (!m_vld || out_ready);
      base = load_addr ? int'(start_addr) : m_acnt;
      code = 0;
      w    = 0;
      if (acc) ref_encode(w, code);
      if (acc && code == 0) begin
         m_vld   = 1;
         m_instr = w;
         m_oaddr = base;
         m_acnt  = (base + 1) % 16384;
         if (m_count < 65535) m_count++;
      end else begin
         if (out_ready) m_vld = 0;
         if (load_addr) m_acnt = start_addr;
      end
      if (acc && code != 0) begin
         if (!m_err || err_clr) m_code = code;
         m_err = 1;
      end else if (err_clr) begin
         m_err = 0; m_code = 0;
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("in_ready",  32'(in_ready),  32'(!m_vld || out_ready));
      chk("out_instr", out_instr,      m_instr);
      chk("out_addr",  32'(out_addr),  32'(m_oaddr));
      chk("count",     32'(count),     32'(m_count));
      chk("err",       32'(err),       32'(m_err));
      chk("err_code",  32'(err_code),  32'(m_code));
   endtask

   // One clock: check outputs mid-cycle, step model at the edge, return just after it.
   task automatic tick();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
      in_valid = v; opcode = op; rd = d; rs1 = a; rs2 = b;
      funct3 = f3; funct7 = f7; imm = im;
   endtask

   function automatic logic [6:0] rand_opcode();
      logic [6:0] tbl [9];
      tbl = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      if ($urandom_range(0, 9) == 0) return 7'($urandom);
      return tbl[$urandom_range(0, 8)];
   endfunction

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 4095)) - 32'd2048;
         1: return 32'($urandom_range(0, 8191)) - 32'd4096;
         2: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1; err_clr = 1'b0; load_addr = 1'b0; start_addr = '0; out_ready = 1'b1;
      set_in(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // addi x1,x0,5
      set_in(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      chk("addi_word", out_instr, 32'h00500093);
      chk("addi_addr", 32'(out_addr), 32'h0);
      chk("addi_count", 32'(count), 32'd1);

      // beq x1,x2,-8
      set_in(1'b1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8);
      tick();
      chk("beq_word", out_instr, 32'hFE208CE3);

      // lui x5,0x12345
      set_in(1'b1, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      tick();
      chk("lui_word", out_instr, 32'h123452B7);
      in_valid = 1'b0;
      tick();

      // Stall: add x3,x1,x2 accepted, sub x4,x1,x2 waits three cycles
      out_ready = 1'b0;
      set_in(1'b1, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
      tick();
      set_in(1'b1, 7'b0110011, 5'd4, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", out_instr, 32'h002081B3);
      end
      out_ready = 1'b1;
      tick();
      chk("release_word", out_instr, 32'h40208233);
      chk("release_addr", 32'(out_addr), 32'd4);
      in_valid = 1'b0;
      tick();

      // Range error then misaligned jal: first code sticks; clear afterwards
      set_in(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
      tick();
      chk("range_err", 32'(err), 32'd1);
      chk("range_code", 32'(err_code), 32'd2);
      chk("range_drop", 32'(out_valid), 32'd0);
      set_in(1'b1, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      tick();
      chk("sticky_code", 32'(err_code), 32'd2);
      in_valid = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_err", 32'(err), 32'd0);
      set_in(1'b1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
      tick();
      chk("after_drop_addr", 32'(out_addr), 32'd5);
      chk("after_drop_count", 32'(count), 32'd6);

      // Address preset with wrap
      load_addr = 1'b1; start_addr = 14'h3FFF;
      tick();
      load_addr = 1'b0;
      chk("preset_addr", 32'(out_addr), 32'h3FFF);
      tick();
      chk("wrap_addr", 32'(out_addr), 32'h0);

      // Reset during a stalled transfer
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_addr", 32'(out_addr), 32'd0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         set_in(1'($urandom_range(0, 3) != 0), rand_opcode(), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
         out_ready  = 1'($urandom_range(0, 3) != 0);
         load_addr  = ($urandom_range(0, 19) == 0);
         start_addr = ($urandom_range(0, 1) == 0) ? 14'h3FFE : 14'($urandom);
         err_clr    = ($urandom_range(0, 9) == 0);
         rst        = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; load_addr = 1'b0; err_clr = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
